// File: rtl/lcd_pkg.sv
// Shared command codes, controller register addresses and FSM encoding for the
// LCD rectangle fill engine.
package lcd_pkg;

  localparam logic [3:0] LCD_CMD_INST = 4'd1;
  localparam logic [3:0] LCD_CMD_DATA = 4'd2;

  localparam logic [15:0] LCD_REG_CASET = 16'h2A00;
  localparam logic [15:0] LCD_REG_PASET = 16'h2B00;
  localparam logic [15:0] LCD_REG_RAMWR = 16'h2C00;

  localparam int unsigned LCD_ADDR_WORDS = 16;
  localparam int unsigned LCD_PIX_CNT_W  = 19;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_MEMWR = 3'd2,
    ST_PIXEL = 3'd3,
    ST_FIN   = 3'd4
  } lcd_state_e;

  // Downstream word layout: {valid, 11'b0, cmd, data}.
  function automatic logic [31:0] lcd_word_pack(input logic       valid,
                                                input logic [3:0]  cmd,
                                                input logic [15:0] data);
    return {valid, 11'b0, cmd, data};
  endfunction

endpackage

// File: rtl/lcd_fill_seq_rom.sv
// Combinational table for the 16-word column/page address preamble: maps the
// word index and the latched rectangle bounds to {cmd, data}.
module lcd_fill_seq_rom
  import lcd_pkg::*;
(
  input  logic [3:0]  idx,
  input  logic [9:0]  x0,
  input  logic [9:0]  x1,
  input  logic [9:0]  y0,
  input  logic [9:0]  y1,
  output logic [3:0]  cmd,
  output logic [15:0] data
);

  logic [9:0]  bound;
  logic [15:0] reg_base;

  // idx[3] selects column/page, idx[2] start/end bound, idx[1] high/low byte,
  // idx[0] register write vs. parameter data.
  always_comb begin
    bound    = idx[3] ? (idx[2] ? y1 : y0) : (idx[2] ? x1 : x0);
    reg_base = idx[3] ? LCD_REG_PASET : LCD_REG_CASET;
    if (!idx[0]) begin
      cmd  = LCD_CMD_INST;
      data = reg_base | {14'h0, idx[2], idx[1]};
    end else begin
      cmd  = LCD_CMD_DATA;
      data = idx[1] ? {8'h0, bound[7:0]} : {14'h0, bound[9:8]};
    end
  end

endmodule

// File: rtl/lcd_fill_engine.sv
// Rectangle fill engine: programs the column/page window, issues memory write,
// then streams N pixels. Define LCD_FILL_COLOR_INC_EN for an incrementing test pattern.
//
// state | meaning
// IDLE  | waiting for start; illegal rectangles rejected here
// ADDR  | 16-word column/page window preamble
// MEMWR | single memory-write command word
// PIXEL | N pixel data words, N counted down to terminal count 1
// FIN   | done pulse, back to IDLE next cycle
module lcd_fill_engine
  import lcd_pkg::*;
#(
  parameter int unsigned MAX_X = 479,
  parameter int unsigned MAX_Y = 799
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [9:0]  x0,
  input  logic [9:0]  x1,
  input  logic [9:0]  y0,
  input  logic [9:0]  y1,
  input  logic [15:0] color,
  input  logic        lcd_busy,
  output logic [31:0] lcd_word,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [9:0] MAX_X_L = MAX_X[9:0];
  localparam logic [9:0] MAX_Y_L = MAX_Y[9:0];

  lcd_state_e state_q, state_d;

  logic [3:0]               idx_q, idx_d;
  logic [LCD_PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [9:0]               x0_q, x0_d, x1_q, x1_d;
  logic [9:0]               y0_q, y0_d, y1_q, y1_d;
  logic [15:0]              pix_color_q, pix_color_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic                     rect_ok;
  logic                     accept;
  logic                     reject;
  logic                     emitting;
  logic                     xfer;
  logic [LCD_PIX_CNT_W-1:0] n_pix;
  logic [9:0]               dx, dy;
  logic [3:0]               rom_cmd;
  logic [15:0]              rom_data;
  logic [3:0]               word_cmd;
  logic [15:0]              word_data;

  assign rect_ok  = (x0 <= x1) && (x1 <= MAX_X_L) && (y0 <= y1) && (y1 <= MAX_Y_L);
  assign accept   = (state_q == ST_IDLE) && start && rect_ok;
  assign reject   = (state_q == ST_IDLE) && start && !rect_ok;
  assign emitting = (state_q == ST_ADDR) || (state_q == ST_MEMWR) || (state_q == ST_PIXEL);
  assign xfer     = emitting && !lcd_busy;

  // 10x10 multiply kept to 19 bits; the largest legal window is 384000 pixels.
  assign dx    = x1 - x0 + 10'd1;
  assign dy    = y1 - y0 + 10'd1;
  assign n_pix = LCD_PIX_CNT_W'(dx) * LCD_PIX_CNT_W'(dy);

  lcd_fill_seq_rom u_seq_rom (
    .idx  (idx_q),
    .x0   (x0_q),
    .x1   (x1_q),
    .y0   (y0_q),
    .y1   (y1_q),
    .cmd  (rom_cmd),
    .data (rom_data)
  );

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pix_cnt_q   <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      pix_color_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pix_cnt_q   <= pix_cnt_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      pix_color_q <= pix_color_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic; every emitting state advances only on a transfer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ADDR;
      ST_ADDR:  if (xfer && (idx_q == 4'(LCD_ADDR_WORDS - 1))) state_d = ST_MEMWR;
      ST_MEMWR: if (xfer) state_d = ST_PIXEL;
      ST_PIXEL: if (xfer && (pix_cnt_q == LCD_PIX_CNT_W'(1))) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    pix_cnt_d   = pix_cnt_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    pix_color_d = pix_color_q;
    done_d      = reject;
    err_d       = reject;
    if (accept) begin
      idx_d       = '0;
      pix_cnt_d   = n_pix;
      x0_d        = x0;
      x1_d        = x1;
      y0_d        = y0;
      y1_d        = y1;
      pix_color_d = color;
    end
    if (xfer && (state_q == ST_ADDR)) begin
      idx_d = idx_q + 4'd1;
    end
    if (xfer && (state_q == ST_PIXEL)) begin
      pix_cnt_d = pix_cnt_q - LCD_PIX_CNT_W'(1);
`ifdef LCD_FILL_COLOR_INC_EN
      pix_color_d = pix_color_q + 16'd1;
`else
      pix_color_d = pix_color_q;
`endif
      if (pix_cnt_q == LCD_PIX_CNT_W'(1)) done_d = 1'b1;
    end
  end

  // Output logic: the word is forced to zero whenever no transfer can happen.
  always_comb begin
    word_cmd  = 4'h0;
    word_data = 16'h0;
    unique case (state_q)
      ST_ADDR: begin
        word_cmd  = rom_cmd;
        word_data = rom_data;
      end
      ST_MEMWR: begin
        word_cmd  = LCD_CMD_INST;
        word_data = LCD_REG_RAMWR;
      end
      ST_PIXEL: begin
        word_cmd  = LCD_CMD_DATA;
        word_data = pix_color_q;
      end
      default: begin
        word_cmd  = 4'h0;
        word_data = 16'h0;
      end
    endcase
    lcd_word = xfer ? lcd_word_pack(1'b1, word_cmd, word_data) : 32'h0;
    busy     = (state_q != ST_IDLE);
    done     = done_q;
    err      = err_q;
  end

endmodule

// File: tb/tb_lcd_fill_engine.sv
// Self-checking bench for lcd_fill_engine: directed scenarios plus randomized
// rectangles and downstream stalls against a word-list reference model.
module tb_lcd_fill_engine;

  localparam int MAX_X = 479;
  localparam int MAX_Y = 799;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [9:0]  x0, x1, y0, y1;
  logic [15:0] color;
  logic        lcd_busy;
  logic [31:0] lcd_word;
  logic        busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] cap_q[$];
  logic [31:0] exp_q[$];
  int done_cnt    = 0;
  int err_cnt     = 0;
  int valid_viol  = 0;
  int fmt_viol    = 0;
  int done_nobusy = 0;
  int err_nodone  = 0;

  always #5 clk = ~clk;

  lcd_fill_engine #(.MAX_X(MAX_X), .MAX_Y(MAX_Y)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .x0       (x0),
    .x1       (x1),
    .y0       (y0),
    .y1       (y1),
    .color    (color),
    .lcd_busy (lcd_busy),
    .lcd_word (lcd_word),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Passive monitor: records transferred words and protocol observations.
  always @(negedge clk) begin
    if (lcd_word[31] === 1'b1) begin
      cap_q.push_back(lcd_word);
      if (lcd_busy) valid_viol++;
    end else if (lcd_word !== 32'h0 && resetn === 1'b1) begin
      fmt_viol++;
    end
    if (lcd_word[30:20] !== 11'h0 && resetn === 1'b1) fmt_viol++;
    if (done === 1'b1) begin
      done_cnt++;
      if (err === 1'b1) err_cnt++;
      else if (busy !== 1'b1) done_nobusy++;
    end
    if (err === 1'b1 && done !== 1'b1) err_nodone++;
  end

  function automatic bit legal(input int a0, input int a1, input int b0, input int b1);
    return (a0 <= a1) && (a1 <= MAX_X) && (b0 <= b1) && (b1 <= MAX_Y);
  endfunction

  function automatic logic [31:0] w_inst(input logic [15:0] d);
    return {1'b1, 11'h0, 4'd1, d};
  endfunction

  function automatic logic [31:0] w_data(input logic [15:0] d);
    return {1'b1, 11'h0, 4'd2, d};
  endfunction

  // Reference: the full ordered word list a legal fill must produce.
  task automatic build_exp(input int a0, input int a1, input int b0, input int b1,
                           input logic [15:0] c);
    int bnd[4];
    int n;
    logic [15:0] r;
    logic [15:0] pc;
    exp_q.delete();
    if (!legal(a0, a1, b0, b1)) return;
    bnd[0] = a0; bnd[1] = a1; bnd[2] = b0; bnd[3] = b1;
    for (int k = 0; k < 4; k++) begin
      r = ((k < 2) ? 16'h2A00 : 16'h2B00) + 16'((k % 2) * 2);
      exp_q.push_back(w_inst(r));
      exp_q.push_back(w_data(16'(bnd[k] / 256)));
      exp_q.push_back(w_inst(r + 16'd1));
      exp_q.push_back(w_data(16'(bnd[k] % 256)));
    end
    exp_q.push_back(w_inst(16'h2C00));
    n = (a1 - a0 + 1) * (b1 - b0 + 1);
    for (int i = 0; i < n; i++) begin
`ifdef LCD_FILL_COLOR_INC_EN
      pc = c + 16'(i);
`else
      pc = c;
`endif
      exp_q.push_back(w_data(pc));
    end
  endtask

  task automatic drive_start(input int a0, input int a1, input int b0, input int b1,
                             input logic [15:0] c, output logic busy_first);
    @(posedge clk); #1;
    x0 = 10'(a0); x1 = 10'(a1); y0 = 10'(b0); y1 = 10'(b1); color = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_first = busy;
  endtask

  task automatic wait_done(input bit rnd, input int budget,
                           output bit timed_out, output logic busy_after);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lcd_busy = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    lcd_busy = 1'b0;
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic test_reset();
    resetn = 1'b0; lcd_busy = 1'b0;
    x0 = 10'd0; x1 = 10'd1; y0 = 10'd0; y1 = 10'd1; color = 16'hF800;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (lcd_word !== 32'h0) begin n_fail++; $display("FAIL reset_word got %h expected 0", lcd_word); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b expected 0", err); end
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    int base, d0, e0, n, bad;
    bit to;
    logic bf, ba;
    base = cap_q.size(); d0 = done_cnt; e0 = err_cnt;
    build_exp(0, 1, 0, 1, 16'hF800);
    drive_start(0, 1, 0, 1, 16'hF800, bf);
    wait_done(1'b0, 200, to, ba);
    n = cap_q.size() - base;
    n_checks++; if (bf !== 1'b1) begin n_fail++; $display("FAIL basic_busy_start got %b expected 1", bf); end
    n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout got timeout expected done"); end
    n_checks++; if (n != 21) begin n_fail++; $display("FAIL basic_count got %0d expected 21", n); end
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < n; i++)
      if (bad < 0 && cap_q[base+i] !== exp_q[i]) bad = i;
    n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL basic_word[%0d] got %h expected %h", bad, cap_q[base+bad], exp_q[bad]); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d expected 1", done_cnt - d0); end
    n_checks++; if (err_cnt != e0) begin n_fail++; $display("FAIL basic_err got %0d expected 0", err_cnt - e0); end
    n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b expected 0", ba); end
  endtask

  task automatic test_single_pixel();
    int base, n, bad;
    bit to;
    logic bf, ba;
    logic [15:0] c;
    c = 16'($urandom);
    base = cap_q.size();
    build_exp(10, 10, 20, 20, c);
    drive_start(10, 10, 20, 20, c, bf);
    wait_done(1'b0, 200, to, ba);
    n = cap_q.size() - base;
    n_checks++; if (to) begin n_fail++; $display("FAIL single_timeout got timeout expected done"); end
    n_checks++; if (n != 18) begin n_fail++; $display("FAIL single_count got %0d expected 18", n); end
    if (n >= 18) begin
      n_checks++; if (cap_q[base+3] !== 32'h8002_000A) begin n_fail++; $display("FAIL single_x0_lo got %h expected 8002000a", cap_q[base+3]); end
      n_checks++; if (cap_q[base+11] !== 32'h8002_0014) begin n_fail++; $display("FAIL single_y0_lo got %h expected 80020014", cap_q[base+11]); end
    end
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < n; i++)
      if (bad < 0 && cap_q[base+i] !== exp_q[i]) bad = i;
    n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL single_word[%0d] got %h expected %h", bad, cap_q[base+bad], exp_q[bad]); end
  endtask

  task automatic test_boundary();
    int base, n, bad;
    bit to;
    logic bf, ba;
    base = cap_q.size();
    build_exp(MAX_X - 1, MAX_X, MAX_Y - 1, MAX_Y, 16'h07E0);
    drive_start(MAX_X - 1, MAX_X, MAX_Y - 1, MAX_Y, 16'h07E0, bf);
    wait_done(1'b0, 200, to, ba);
    n = cap_q.size() - base;
    n_checks++; if (to || n != exp_q.size()) begin n_fail++; $display("FAIL boundary_count got %0d expected %0d", n, exp_q.size()); end
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < n; i++)
      if (bad < 0 && cap_q[base+i] !== exp_q[i]) bad = i;
    n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL boundary_word[%0d] got %h expected %h", bad, cap_q[base+bad], exp_q[bad]); end
  endtask

  task automatic test_stall();
    int base, n, bad, stall_bad, held;
    bit to, reached;
    logic bf, ba;
    base = cap_q.size();
    build_exp(2, 5, 3, 5, 16'h1234);
    drive_start(2, 5, 3, 5, 16'h1234, bf);
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk);
      if (cap_q.size() - base >= 19) reached = 1'b1;
    end
    n_checks++; if (!reached) begin n_fail++; $display("FAIL stall_reach_pixel got timeout expected pixel phase"); end
    @(posedge clk); #1;
    lcd_busy = 1'b1;
    held = cap_q.size();
    stall_bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (lcd_word[31] !== 1'b0 || busy !== 1'b1) stall_bad++;
      if (i < 4) begin @(posedge clk); #1; end
    end
    n_checks++; if (stall_bad != 0 || cap_q.size() != held) begin n_fail++; $display("FAIL stall_valid got %0d bad cycles expected 0", stall_bad); end
    @(posedge clk); #1;
    lcd_busy = 1'b0;
    wait_done(1'b0, 200, to, ba);
    n = cap_q.size() - base;
    n_checks++; if (to || n != 29) begin n_fail++; $display("FAIL stall_count got %0d expected 29", n); end
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < n; i++)
      if (bad < 0 && cap_q[base+i] !== exp_q[i]) bad = i;
    n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL stall_word[%0d] got %h expected %h", bad, cap_q[base+bad], exp_q[bad]); end
  endtask

  task automatic test_reject();
    int rect[3][4];
    int base;
    logic bf;
    rect[0] = '{5, 4, 0, 0};
    rect[1] = '{0, 0, 0, 800};
    rect[2] = '{0, 480, 7, 7};
    for (int k = 0; k < 3; k++) begin
      base = cap_q.size();
      drive_start(rect[k][0], rect[k][1], rect[k][2], rect[k][3], 16'hABCD, bf);
      @(negedge clk);
      n_checks++; if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reject%0d_pulse got done=%b err=%b busy=%b expected 1 1 0", k, done, err, busy); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reject%0d_width got done=%b err=%b expected 0 0", k, done, err); end
      n_checks++; if (cap_q.size() != base) begin n_fail++; $display("FAIL reject%0d_words got %0d expected 0", k, cap_q.size() - base); end
    end
  endtask

  task automatic test_start_ignored();
    int base, n, bad;
    bit to;
    logic bf, ba;
    base = cap_q.size();
    build_exp(0, 1, 0, 1, 16'hF800);
    drive_start(0, 1, 0, 1, 16'hF800, bf);
    repeat (4) @(posedge clk);
    #1;
    x0 = 10'd0; x1 = 10'd3; y0 = 10'd0; y1 = 10'd3; color = 16'h1111;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, 200, to, ba);
    n = cap_q.size() - base;
    n_checks++; if (to || n != 21) begin n_fail++; $display("FAIL ignore_count got %0d expected 21", n); end
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < n; i++)
      if (bad < 0 && cap_q[base+i] !== exp_q[i]) bad = i;
    n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL ignore_word[%0d] got %h expected %h", bad, cap_q[base+bad], exp_q[bad]); end
    n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_end got %b expected 0", ba); end
  endtask

  task automatic test_reset_mid_addr();
    int base, d0, n, bad;
    bit to;
    logic bf, ba;
    d0 = done_cnt;
    drive_start(0, 1, 0, 1, 16'hF800, bf);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    n_checks++; if (lcd_word !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs got word=%h busy=%b done=%b err=%b expected all 0", lcd_word, busy, done, err); end
    repeat (30) @(negedge clk);
    n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL midreset_no_done got %0d pulses expected 0", done_cnt - d0); end
    base = cap_q.size();
    build_exp(0, 1, 0, 1, 16'hF800);
    drive_start(0, 1, 0, 1, 16'hF800, bf);
    wait_done(1'b0, 200, to, ba);
    n = cap_q.size() - base;
    n_checks++; if (to || n != 21) begin n_fail++; $display("FAIL midreset_count got %0d expected 21", n); end
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < n; i++)
      if (bad < 0 && cap_q[base+i] !== exp_q[i]) bad = i;
    n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL midreset_word[%0d] got %h expected %h", bad, cap_q[base+bad], exp_q[bad]); end
  endtask

  task automatic test_random();
    int a0, a1, b0, b1, m, base, d0, e0, n, bad;
    bit to, ok;
    logic bf, ba;
    logic [15:0] c;
    for (int it = 0; it < 16; it++) begin
      a0 = $urandom_range(0, MAX_X);
      b0 = $urandom_range(0, MAX_Y);
      a1 = a0 + $urandom_range(0, 3);
      b1 = b0 + $urandom_range(0, 3);
      m  = $urandom_range(0, 5);
      if (m == 0 && a0 > 0) a1 = a0 - 1;
      if (m == 1) b1 = MAX_Y + 1 + $urandom_range(0, 20);
      if (a1 > 1023) a1 = 1023;
      if (b1 > 1023) b1 = 1023;
      c  = 16'($urandom);
      ok = legal(a0, a1, b0, b1);
      base = cap_q.size(); d0 = done_cnt; e0 = err_cnt;
      build_exp(a0, a1, b0, b1, c);
      drive_start(a0, a1, b0, b1, c, bf);
      wait_done(1'b1, 500, to, ba);
      n = cap_q.size() - base;
      n_checks++; if (to || n != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count got %0d expected %0d", it, n, exp_q.size()); end
      bad = -1;
      for (int i = 0; i < exp_q.size() && i < n; i++)
        if (bad < 0 && cap_q[base+i] !== exp_q[i]) bad = i;
      n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL rand%0d_word[%0d] got %h expected %h", it, bad, cap_q[base+bad], exp_q[bad]); end
      n_checks++; if (done_cnt - d0 != 1 || err_cnt - e0 != (ok ? 0 : 1)) begin n_fail++; $display("FAIL rand%0d_done_err got %0d/%0d expected 1/%0d", it, done_cnt - d0, err_cnt - e0, ok ? 0 : 1); end
    end
  endtask

`ifdef LCD_FILL_COLOR_INC_EN
  task automatic test_color_inc();
    logic [15:0] want[4];
    int base, n;
    bit to;
    logic bf, ba;
    want = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    base = cap_q.size();
    drive_start(0, 1, 0, 1, 16'hFFFE, bf);
    wait_done(1'b0, 200, to, ba);
    n = cap_q.size() - base;
    n_checks++; if (to || n != 21) begin n_fail++; $display("FAIL colorinc_count got %0d expected 21", n); end
    if (n >= 21) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (cap_q[base+17+i] !== {1'b1, 11'h0, 4'd2, want[i]}) begin n_fail++; $display("FAIL colorinc_pix%0d got %h expected %h", i, cap_q[base+17+i], want[i]); end
      end
    end
  endtask
`endif

  task automatic test_protocol();
    n_checks++; if (valid_viol != 0) begin n_fail++; $display("FAIL proto_valid_while_busy got %0d expected 0", valid_viol); end
    n_checks++; if (fmt_viol != 0) begin n_fail++; $display("FAIL proto_word_format got %0d expected 0", fmt_viol); end
    n_checks++; if (done_nobusy != 0) begin n_fail++; $display("FAIL proto_done_busy got %0d expected 0", done_nobusy); end
    n_checks++; if (err_nodone != 0) begin n_fail++; $display("FAIL proto_err_alone got %0d expected 0", err_nodone); end
  endtask

  initial begin
    start = 1'b0; lcd_busy = 1'b0; resetn = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
    test_reset();
    test_basic();
    test_single_pixel();
    test_boundary();
    test_stall();
    test_reject();
    test_start_ignored();
    test_reset_mid_addr();
    test_random();
`ifdef LCD_FILL_COLOR_INC_EN
    test_color_inc();
`endif
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
